id_ex_operand_stage: RTL

- Pipeline register between decode and the ALU.
- Latches decoded operands and control, selects the ALU `a`/`b` sources (register, shamt, immediate), and resolves RAW hazards by forwarding from the MEM and WB stages.
- Drives `alu_a`, `alu_b` and `alu_aluc` directly into the ALU, and flags load-use hazards back to decode.
- Supports stall (hold) and flush (bubble).

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/fwd_mux.sv | 32 +++
 rtl/id_ex_operand_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes and the operand-source encodings
// used by decode and the ID/EX stage.
package cpu_pkg;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  // Shifts carry the amount on a and the shifted value on b.
  typedef enum logic [1:0] {
    ASEL_RS       = 2'd0,
    ASEL_SHAMT    = 2'd1,
    ASEL_RS_SHAMT = 2'd2,
    ASEL_ZERO     = 2'd3
  } asel_e;

  typedef enum logic [1:0] {
    BSEL_RT      = 2'd0,
    BSEL_IMM_SX  = 2'd1,
    BSEL_IMM_ZX  = 2'd2,
    BSEL_ZERO    = 2'd3
  } bsel_e;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding selector for one source operand: MEM producer beats WB producer,
// and register 0 is never forwarded.
module fwd_mux #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] addr,
  input  logic [XLEN-1:0]    stored,
  input  logic               mem_we,
  input  logic [RADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]    mem_data,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    eff
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_we && (mem_addr != '0) && (mem_addr == addr);
  assign wb_hit  = wb_we  && (wb_addr  != '0) && (wb_addr  == addr);

  always_comb begin
    eff = stored;
    if (mem_hit)
      eff = mem_data;
    else if (wb_hit)
      eff = wb_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: latches decoded fields, forwards from MEM/WB,
// selects ALU operands and reports load-use hazards to decode.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [RADDR_W-1:0] in_rs_addr,
  input  logic [RADDR_W-1:0] in_rt_addr,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]    in_rs_data,
  input  logic [XLEN-1:0]    in_rt_data,
  input  logic [15:0]        in_imm16,
  input  logic [4:0]         in_shamt,
  input  logic [1:0]         in_asel,
  input  logic [1:0]         in_bsel,
  input  logic [3:0]         in_aluc,
  input  logic               in_reg_we,
  input  logic               in_is_load,
  input  logic               mem_fwd_we,
  input  logic [RADDR_W-1:0] mem_fwd_addr,
  input  logic [XLEN-1:0]    mem_fwd_data,
  input  logic               wb_fwd_we,
  input  logic [RADDR_W-1:0] wb_fwd_addr,
  input  logic [XLEN-1:0]    wb_fwd_data,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [3:0]         alu_aluc,
  output logic               out_valid,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_reg_we,
  output logic               out_is_load,
  output logic [XLEN-1:0]    out_rt_fwd,
  output logic               load_use_hazard
);

  logic [RADDR_W-1:0] rs_addr_q, rt_addr_q;
  logic [XLEN-1:0]    rs_data_q, rt_data_q;
  logic [15:0]        imm_q;
  logic [4:0]         shamt_q;
  logic [1:0]         asel_q, bsel_q;
  logic [XLEN-1:0]    rs_eff, rt_eff;

  logic wb_hits_in_rs, wb_hits_in_rt, wb_hits_q_rs, wb_hits_q_rt;

  // WB writes the regfile in the same cycle decode reads it, so the read
  // data may be stale; the same WB value can also retire while we are held.
  assign wb_hits_in_rs = wb_fwd_we && (wb_fwd_addr != '0) && (wb_fwd_addr == in_rs_addr);
  assign wb_hits_in_rt = wb_fwd_we && (wb_fwd_addr != '0) && (wb_fwd_addr == in_rt_addr);
  assign wb_hits_q_rs  = wb_fwd_we && (wb_fwd_addr != '0) && (wb_fwd_addr == rs_addr_q);
  assign wb_hits_q_rt  = wb_fwd_we && (wb_fwd_addr != '0) && (wb_fwd_addr == rt_addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_reg_we  <= 1'b0;
      out_is_load <= 1'b0;
      out_rd_addr <= '0;
      alu_aluc    <= 4'b0000;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      asel_q      <= '0;
      bsel_q      <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_reg_we  <= 1'b0;
      out_is_load <= 1'b0;
      out_rd_addr <= '0;
      alu_aluc    <= ALU_ADDU;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      asel_q      <= '0;
      bsel_q      <= '0;
    end else if (stall) begin
      if (wb_hits_q_rs) rs_data_q <= wb_fwd_data;
      if (wb_hits_q_rt) rt_data_q <= wb_fwd_data;
    end else begin
      out_valid   <= in_valid;
      out_reg_we  <= in_reg_we;
      out_is_load <= in_is_load;
      out_rd_addr <= in_rd_addr;
      alu_aluc    <= in_aluc;
      rs_addr_q   <= in_rs_addr;
      rt_addr_q   <= in_rt_addr;
      rs_data_q   <= wb_hits_in_rs ? wb_fwd_data : in_rs_data;
      rt_data_q   <= wb_hits_in_rt ? wb_fwd_data : in_rt_data;
      imm_q       <= in_imm16;
      shamt_q     <= in_shamt;
      asel_q      <= in_asel;
      bsel_q      <= in_bsel;
    end
  end

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs (
    .addr     (rs_addr_q),
    .stored   (rs_data_q),
    .mem_we   (mem_fwd_we),
    .mem_addr (mem_fwd_addr),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_fwd_we),
    .wb_addr  (wb_fwd_addr),
    .wb_data  (wb_fwd_data),
    .eff      (rs_eff)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rt (
    .addr     (rt_addr_q),
    .stored   (rt_data_q),
    .mem_we   (mem_fwd_we),
    .mem_addr (mem_fwd_addr),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_fwd_we),
    .wb_addr  (wb_fwd_addr),
    .wb_data  (wb_fwd_data),
    .eff      (rt_eff)
  );

  always_comb begin
    alu_a = '0;
    case (asel_q)
      ASEL_RS:       alu_a = rs_eff;
      ASEL_SHAMT:    alu_a = {{(XLEN-5){1'b0}}, shamt_q};
      ASEL_RS_SHAMT: alu_a = {{(XLEN-5){1'b0}}, rs_eff[4:0]};
      default:       alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (bsel_q)
      BSEL_RT:     alu_b = rt_eff;
      BSEL_IMM_SX: alu_b = {{(XLEN-16){imm_q[15]}}, imm_q};
      BSEL_IMM_ZX: alu_b = {{(XLEN-16){1'b0}}, imm_q};
      default:     alu_b = '0;
    endcase
  end

  assign out_rt_fwd = rt_eff;

  // Load data is only available after MEM, so a dependent instruction in
  // decode must wait; the hazard controller turns this into stall + flush.
  assign load_use_hazard = out_valid && out_is_load && (out_rd_addr != '0) &&
                           ((out_rd_addr == in_rs_addr) || (out_rd_addr == in_rt_addr)) &&
                           in_valid;

endmodule
